display_scan4: RTL and testbench
================================

// Module: display_scan4
// PURPOSE
//  Upstream driver for the single-digit 7-segment decoder.
//  - Accepts a 14-bit binary value and converts it to four BCD digits using a sequential double-dabble FSM.
//  - Time-multiplexes the four digits onto one digit-code bus, with active-low anode enables for a 4-digit common-anode display.
//  - The digit-code output feeds the decoder's 5-bit input directly.
// PARAMETERS
//  REFRESH_DIV  50000  clock cycles each digit stays selected (>=2)
//  BLANK_LZ     1      1 = suppress leading zeros, 0 = show all four digits
// PORTS
//  clock     in   1   system clock, all logic on posedge
//  reset     in   1   synchronous, active-high reset
//  value     in   14  binary value to display, valid when load=1
//  load      in   1   one-cycle request to capture value
//  busy      out  1   conversion in progress; load ignored while high
//  overflow  out  1   last accepted value was >9999
//  digit     out  5   BCD code of selected digit (0..9), to decoder input
//  an        out  4   anode enables, active low, an[0]=units .. an[3]=thousands
// BEHAVIOUR
//  Reset values (reset=1 at a posedge; reset wins over every other input):
//   - busy=0, overflow=0, digit=0, an=4'b1111.
//   - BCD store = 0000, scan index=0, refresh counter=0, FSM=IDLE.
//  FSM states: IDLE -> CONVERT -> COMMIT -> IDLE.
//   - IDLE: load=1 at edge N captures value into the shift register and sets FSM=CONVERT.
//   - CONVERT: 14 cycles (edges N+1..N+14). Each cycle, add 3 to any BCD nibble >=5, then shift left by 1.
//   - COMMIT: edge N+15. Writes all four nibbles into the BCD store atomically. Updates overflow. Returns to IDLE.
//   - busy=1 from after edge N until after edge N+15.
//   - A new load is accepted at edge N+16 at the earliest.
//  Overflow: value>9999 is saturated to 9999 before conversion, and overflow=1 at COMMIT.
//   - overflow is cleared by the next COMMIT of an in-range value.
//  load while busy=1, including during COMMIT, is dropped; there is no queueing.
//  Scanning is independent of the FSM and runs continuously from the BCD store.
//   - The old digits stay displayed until COMMIT.
//   - The display never shows a partially converted value.
//  Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
//   - On wrap, scan index advances 0->1->2->3->0.
//  digit is registered: digit <= store[index] on each edge.
//  an lags digit by exactly one cycle. This aligns with the decoder's one-cycle registered segment output.
//   - After the lag, an = ~(1<<index), with blanking applied.
//  Blanking (BLANK_LZ=1):
//   - digit i (i>=1) is blanked, i.e. its an bit is held 1, when nibble i and all higher nibbles are 0.
//   - digit 0 is never blanked, so value 0 shows a single "0".
//   - The decoder holds its output for codes >9, so blanking is done only through an, never through digit.
//  At most one an bit is low in any cycle.
//  Reset mid-conversion aborts: the store is cleared and partial results are discarded.
// TESTING
//  1. Reset held 3 cycles -> an=1111, digit=0, busy=0, overflow=0. After release, digit 0 scans showing "0".
//  2. REFRESH_DIV=4; load value=1234 -> busy high exactly 15 cycles. Scan yields digit 4,3,2,1 with an 1110,1101,1011,0111, each for 4 cycles, and an lags digit by 1 cycle.
//  3. load value=12000 -> store=9,9,9,9 and overflow=1. Then load 5 -> overflow=0.
//  4. BLANK_LZ=1, load 7 -> only an[0] ever goes low. load 0 -> only an[0] goes low and digit=0. With BLANK_LZ=0, load 7 -> all four anodes cycle.
//  5. load 1234, then pulse load=1 with 9876 at edges N+5 and N+15 -> both ignored, and the store ends at 1234.
//  6. load 4321, assert reset at edge N+7 -> store=0, busy=0, an=1111. The next load converts correctly.

Source files
------------

// File: rtl/display_scan4.sv
// ---------------------------------------------------------------------------
// display_scan4
//
// Front end for a 4-digit common-anode 7-segment display whose segments are
// produced by a separate single-digit decoder with a one-cycle registered
// output.
//
// A 14-bit binary value is converted to four BCD digits by a sequential
// double-dabble engine: one shift per cycle, 14 cycles per conversion. The
// finished digits are written into a display store in a single cycle, so the
// scanner never sees a half-converted number. Independently of the
// converter, the scanner walks the four digits. It puts the selected BCD
// code on `digit` and drives the matching active-low anode one cycle later,
// so the anode lines up with the decoder's registered segment output.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays selected (>= 2)
//   BLANK_LZ     1 = suppress leading zeros, 0 = always light all digits
//
// Ports
//   clock     in   1   system clock, everything on posedge
//   reset     in   1   synchronous, active-high; wins over every other input
//   value     in   14  binary value, sampled when load=1 and the engine idles
//   load      in   1   one-cycle capture request; dropped while busy=1
//   busy      out  1   conversion in progress (capture edge through commit)
//   overflow  out  1   last committed value was above 9999 (shown as 9999)
//   digit     out  5   BCD code of the selected digit, 0..9
//   an        out  4   active-low anodes, an[0]=units .. an[3]=thousands
// ---------------------------------------------------------------------------
module display_scan4 #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  digit,
    output logic [3:0]  an
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int              CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [13:0]     MAX_VALUE = 14'd9999;
    // The engine performs one shift per input bit; the step counter runs
    // 0..13 and the last shift happens when it reads 13.
    localparam logic [3:0]      LAST_STEP = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    // -----------------------------------------------------------------------
    // Conversion engine state
    // -----------------------------------------------------------------------
    state_t      state;
    logic [13:0] bin_sr;       // binary bits still to be shifted in, MSB first
    logic [15:0] bcd_sr;       // partial BCD result, four nibbles
    logic [3:0]  step;         // shift counter during S_CONVERT
    logic        ovf_pending;  // saturation flag carried to the commit

    // Display store: only ever written with a complete conversion result.
    logic [15:0] bcd_store;

    // -----------------------------------------------------------------------
    // Scanner state
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;     // digit being fetched this cycle
    logic [1:0]       shown_idx;    // digit currently presented on `digit`
    logic             shown_blank;  // that digit is a suppressed leading zero
    logic             shown_vld;    // `digit` holds a fetched value

    // -----------------------------------------------------------------------
    // Double-dabble correction: every nibble of 5 or more gets +3 before the
    // shift, so that the shift carries it correctly into the next decade.
    // -----------------------------------------------------------------------
    logic [15:0] bcd_adj;

    // NOTE: every signal assigned in always_comb gets a full default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit fetch and leading-zero detection for the scan index.
    // A digit above position 0 is a leading zero when it and every higher
    // nibble are zero; position 0 is always lit so a value of 0 shows "0".
    // -----------------------------------------------------------------------
    logic [3:0] nibble_nz;
    logic [3:0] cur_nibble;
    logic       cur_blank;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nibble_nz[i] = |bcd_store[4*i +: 4];
        end
        cur_nibble = bcd_store[{scan_idx, 2'b00} +: 4];
        cur_blank  = BLANK_LZ
                  && (scan_idx != 2'd0)
                  && ((nibble_nz >> scan_idx) == 4'd0);
    end

    // Anode pattern for the digit presented last cycle; at most one bit low.
    logic [3:0] an_next;

    always_comb begin
        an_next = 4'b1111;
        if (shown_vld && !shown_blank) begin
            an_next = ~(4'b0001 << shown_idx);
        end
    end

    // -----------------------------------------------------------------------
    // Conversion FSM: IDLE -> CONVERT (14 cycles) -> COMMIT -> IDLE.
    // busy rises on the capture edge and falls on the commit edge, so a new
    // load can be taken no earlier than the edge after the commit.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the display store is a handful of flops, not a RAM, and a
            // reset (including one mid-conversion) must clear it, so it is
            // reset together with the control state.
            state       <= S_IDLE;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            bin_sr      <= '0;
            bcd_sr      <= '0;
            step        <= '0;
            ovf_pending <= 1'b0;
            bcd_store   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        // Out-of-range inputs are saturated before conversion
                        // so the result always fits four BCD digits.
                        if (value > MAX_VALUE) begin
                            bin_sr      <= MAX_VALUE;
                            ovf_pending <= 1'b1;
                        end else begin
                            bin_sr      <= value;
                            ovf_pending <= 1'b0;
                        end
                        bcd_sr <= '0;
                        step   <= '0;
                        busy   <= 1'b1;
                        state  <= S_CONVERT;
                    end
                end

                S_CONVERT: begin
                    // Shift the corrected BCD part and the binary part left
                    // as one register; the binary MSB enters the BCD LSB.
                    bcd_sr <= {bcd_adj[14:0], bin_sr[13]};
                    bin_sr <= {bin_sr[12:0], 1'b0};
                    if (step == LAST_STEP) begin
                        state <= S_COMMIT;
                    end else begin
                        step <= step + 4'd1;
                    end
                end

                S_COMMIT: begin
                    // All four nibbles land in the store on the same edge.
                    bcd_store <= bcd_sr;
                    overflow  <= ovf_pending;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Scanner: free-running, reads only the committed store.
    // Cycle k  : digit <= store[scan_idx], remember which index that was.
    // Cycle k+1: an    <= anode for the remembered index (or all off).
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            digit       <= 5'd0;
            shown_idx   <= 2'd0;
            shown_blank <= 1'b0;
            shown_vld   <= 1'b0;
            an          <= 4'b1111;
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_ONE;
            end

            // Blanking acts only on the anodes: the decoder holds its output
            // for codes above 9, so the digit bus always carries a real BCD code.
            digit       <= {1'b0, cur_nibble};
            shown_idx   <= scan_idx;
            shown_blank <= cur_blank;
            shown_vld   <= 1'b1;
            an          <= an_next;
        end
    end

endmodule

// File: tb/tb_display_scan4.sv
// ---------------------------------------------------------------------------
// tb_display_scan4
//
// Two instances share all inputs: `dut` suppresses leading zeros, `dut_nb`
// shows all four digits. The stimulus process issues loads and pushes the
// expected displayed number into a queue. A monitor waits for each
// conversion to finish (busy falling), pops the expectation and reads the
// display back through the scan outputs. For every cycle it pairs the lit
// anode with the digit code presented one cycle earlier.
// The expected digits come from plain decimal arithmetic on the value.
// ---------------------------------------------------------------------------
module tb_display_scan4;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [13:0] value;

    logic        busy, overflow;
    logic [4:0]  digit;
    logic [3:0]  an;
    logic        busy_nb, overflow_nb;
    logic [4:0]  digit_nb;
    logic [3:0]  an_nb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int val;   // number the display should show
        bit ovf;   // expected overflow flag
    } exp_t;

    exp_t exp_q[$];
    bit   mon_idle = 1'b1;
    bit   prev_busy = 1'b0;
    int   busy_cycles = 0;

    always #5 clock = ~clock;

    display_scan4 #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .digit    (digit),
        .an       (an)
    );

    display_scan4 #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy_nb),
        .overflow (overflow_nb),
        .digit    (digit_nb),
        .an       (an_nb)
    );

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pow10(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    function automatic int dec_digit(input int v, input int i);
        return (v / pow10(i)) % 10;
    endfunction

    // With leading-zero suppression, position i is lit when the number has
    // at least i+1 decimal digits; position 0 is always lit.
    function automatic bit lit_lz(input int v, input int i);
        return (i == 0) || (v >= pow10(i));
    endfunction

    // Watch one full scan rotation (4*DIV cycles) of both instances and
    // compare what is shown against the decimal digits of `val`.
    task automatic scan_check(input int val, input string tag);
        int         cnt_a[4] = '{default: 0};
        int         cnt_b[4] = '{default: 0};
        int         bad_a = 0;
        int         bad_b = 0;
        int         multi = 0;
        logic [4:0] pa, pb;

        @(negedge clock);
        pa = digit;
        pb = digit_nb;
        repeat (4 * DIV) begin
            @(negedge clock);
            if ($countones(~an) > 1 || $countones(~an_nb) > 1) multi++;
            for (int k = 0; k < 4; k++) begin
                if (an[k] === 1'b0) begin
                    cnt_a[k]++;
                    if (pa !== 5'(dec_digit(val, k))) bad_a++;
                end
                if (an_nb[k] === 1'b0) begin
                    cnt_b[k]++;
                    if (pb !== 5'(dec_digit(val, k))) bad_b++;
                end
            end
            pa = digit;
            pb = digit_nb;
        end

        check($sformatf("%s_one_anode", tag), multi, 0);
        check($sformatf("%s_lz_digit_errs", tag), bad_a, 0);
        check($sformatf("%s_nb_digit_errs", tag), bad_b, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_lz_an%0d_cycles", tag, k), cnt_a[k], lit_lz(val, k) ? DIV : 0);
            check($sformatf("%s_nb_an%0d_cycles", tag, k), cnt_b[k], DIV);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue a load while the engine is idle and record what should appear.
    task automatic do_load(input int v);
        exp_t e;
        e.val = (v > 9999) ? 9999 : v;
        e.ovf = (v > 9999);
        exp_q.push_back(e);
        value = v[13:0];
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !mon_idle) && n < 400) begin
            tick();
            n++;
        end
        check($sformatf("%s_completed", tag), (exp_q.size() == 0 && mon_idle), 1);
    endtask

    // -----------------------------------------------------------------------
    // Monitor: one scoreboard entry per completed conversion.
    // -----------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0) begin
                prev_busy   = 1'b0;
                busy_cycles = 0;
            end else begin
                if (busy === 1'b1) begin
                    busy_cycles++;
                end else if (prev_busy) begin
                    mon_idle = 1'b0;
                    check("busy_cycles", busy_cycles, 15);
                    busy_cycles = 0;
                    check("commit_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("v%0d_overflow", e.val), overflow, e.ovf);
                        check($sformatf("v%0d_overflow_nb", e.val), overflow_nb, e.ovf);
                        scan_check(e.val, $sformatf("v%0d", e.val));
                    end
                    mon_idle = 1'b1;
                end
                prev_busy = (busy === 1'b1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int v;
        int r;
        int off;

        reset = 1'b1;
        load  = 1'b0;
        value = '0;

        // Reset held for three edges.
        repeat (3) tick();
        @(negedge clock);
        check("rst_an", an, 4'hF);
        check("rst_digit", digit, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_an_nb", an_nb, 4'hF);
        check("rst_busy_nb", busy_nb, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        scan_check(0, "after_reset");

        // Directed values: normal, saturated, back in range, leading zeros.
        do_load(1234);  wait_done("t1234");
        do_load(12000); wait_done("t12000");
        do_load(5);     wait_done("t5");
        do_load(7);     wait_done("t7");
        do_load(0);     wait_done("t0");

        // Loads during conversion (edge N+5) and during commit (edge N+15)
        // are dropped.
        do_load(1234);                  // now just after edge N
        repeat (4) tick();              // just after edge N+4
        value = 14'd9876; load = 1'b1;
        tick();                         // edge N+5 sees load
        load = 1'b0;
        repeat (9) tick();              // just after edge N+14
        value = 14'd9876; load = 1'b1;
        tick();                         // edge N+15 (commit) sees load
        load = 1'b0;
        wait_done("t_drop");

        // Reset in the middle of a conversion discards it.
        do_load(4321);                  // just after edge N
        repeat (6) tick();              // just after edge N+6
        reset = 1'b1;
        tick();                         // edge N+7 resets
        exp_q.delete();
        @(negedge clock);
        check("abort_an", an, 4'hF);
        check("abort_busy", busy, 0);
        check("abort_digit", digit, 0);
        check("abort_overflow", overflow, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        scan_check(0, "after_abort");
        do_load(4321);  wait_done("t4321");

        // Random values, some out of range, some with a dropped load pulse.
        repeat (20) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      v = int'($urandom_range(10000, 16383));
            else if (r < 3)  v = int'($urandom_range(0, 99));
            else             v = int'($urandom_range(0, 9999));
            do_load(v);
            if ($urandom_range(0, 1) == 1) begin
                off = int'($urandom_range(1, 15));
                repeat (off - 1) tick();
                value = 14'($urandom_range(0, 16383));
                load  = 1'b1;
                tick();
                load  = 1'b0;
            end
            wait_done("t_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
